melody_player: RTL and testbench

//  Note sequencer upstream of SoundGenerator. Reads {Duration_ms, HalfPeriod_us} note words from
//  a synchronous note memory (ROM/BRAM), issues each to SoundGenerator, waits for its Done, then advances.
//  A word with Duration_ms == 0 is the end-of-melody marker; optional looping replays the melody.

---
 rtl/melody_player.sv | 166 ++++++++++++++++
 tb/tb_melody_player.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/melody_player.sv
// Note sequencer: fetches {Duration_ms, HalfPeriod_us} words from a synchronous note memory,
// hands each note to the sound generator, waits for its completion and advances until the end marker.
module melody_player #(
  parameter int ADDR_WIDTH      = 8,
  parameter int NOTE_GAP_CYCLES = 0
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  Start_i,
  input  logic                  Stop_i,
  input  logic                  Loop_i,
  input  logic [ADDR_WIDTH-1:0] StartAddr_i,
  output logic [ADDR_WIDTH-1:0] Address_o,
  input  logic [31:0]           Data_i,
  output logic                  SoundStart_o,
  output logic                  SoundFinish_o,
  output logic [15:0]           Duration_ms_o,
  output logic [15:0]           HalfPeriod_us_o,
  input  logic                  SoundDone_i,
  output logic                  Busy_o,
  output logic                  Done_o
);

  localparam int GW = $clog2(NOTE_GAP_CYCLES + 2);
  localparam logic [GW-1:0] GAP_LOAD = GW'((NOTE_GAP_CYCLES > 0) ? (NOTE_GAP_CYCLES - 1) : 0);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    READ = 3'd1,
    EVAL = 3'd2,
    WAIT = 3'd3,
    GAP  = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] start_addr_q, start_addr_d;
  logic [15:0]           dur_q, dur_d;
  logic [15:0]           hp_q, hp_d;
  logic [GW-1:0]         gap_cnt_q, gap_cnt_d;
  logic                  busy_q, busy_d;
  logic                  snd_start_q, snd_start_d;
  logic                  snd_finish_q, snd_finish_d;
  logic                  done_q, done_d;

  // Next-state and next-output computation; Stop_i overrides everything else outside IDLE.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    start_addr_d = start_addr_q;
    dur_d        = dur_q;
    hp_d         = hp_q;
    gap_cnt_d    = gap_cnt_q;
    busy_d       = busy_q;
    snd_start_d  = 1'b0;
    snd_finish_d = 1'b0;
    done_d       = 1'b0;

    case (state_q)
      IDLE: begin
        if (Start_i && !Stop_i) begin
          state_d      = READ;
          addr_d       = StartAddr_i;
          start_addr_d = StartAddr_i;
          busy_d       = 1'b1;
        end else begin
          busy_d = 1'b0;
        end
      end
      READ: begin
        state_d = EVAL;
      end
      EVAL: begin
        if (Data_i[31:16] == 16'd0) begin
          if (Loop_i) begin
            addr_d  = start_addr_q;
            state_d = READ;
          end else begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
          end
        end else begin
          dur_d       = Data_i[31:16];
          hp_d        = Data_i[15:0];
          snd_start_d = 1'b1;
          state_d     = WAIT;
        end
      end
      WAIT: begin
        if (SoundDone_i) begin
          addr_d = addr_q + ADDR_WIDTH'(1);
          if (NOTE_GAP_CYCLES > 0) begin
            gap_cnt_d = GAP_LOAD;
            state_d   = GAP;
          end else begin
            state_d = READ;
          end
        end else begin
          state_d = WAIT;
        end
      end
      GAP: begin
        if (gap_cnt_q == GW'(0)) begin
          state_d = READ;
        end else begin
          gap_cnt_d = gap_cnt_q - GW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase

    // A stop only cuts off a note the generator is actually playing.
    if (Stop_i && (state_q != IDLE)) begin
      state_d      = IDLE;
      addr_d       = addr_q;
      dur_d        = dur_q;
      hp_d         = hp_q;
      busy_d       = 1'b0;
      snd_start_d  = 1'b0;
      done_d       = 1'b0;
      snd_finish_d = (state_q == WAIT);
    end else begin
      snd_finish_d = 1'b0;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      start_addr_q <= '0;
      dur_q        <= 16'd0;
      hp_q         <= 16'd0;
      gap_cnt_q    <= '0;
      busy_q       <= 1'b0;
      snd_start_q  <= 1'b0;
      snd_finish_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      start_addr_q <= start_addr_d;
      dur_q        <= dur_d;
      hp_q         <= hp_d;
      gap_cnt_q    <= gap_cnt_d;
      busy_q       <= busy_d;
      snd_start_q  <= snd_start_d;
      snd_finish_q <= snd_finish_d;
      done_q       <= done_d;
    end
  end

  assign Address_o       = addr_q;
  assign Duration_ms_o   = dur_q;
  assign HalfPeriod_us_o = hp_q;
  assign Busy_o          = busy_q;
  assign SoundStart_o    = snd_start_q;
  assign SoundFinish_o   = snd_finish_q;
  assign Done_o          = done_q;

endmodule

// File: tb/tb_melody_player.sv
// Bench for melody_player: directed scenarios with literal expectations, then random traffic,
// all compared every cycle against a note-scheduling reference model.
module tb_melody_player;

  localparam int AW  = 4;
  localparam int GAP = 2;

  logic          Clock = 1'b0;
  logic          Reset, Start_i, Stop_i, Loop_i, SoundDone_i;
  logic [AW-1:0] StartAddr_i;
  logic [AW-1:0] Address_o;
  logic [31:0]   Data_i;
  logic          SoundStart_o, SoundFinish_o, Busy_o, Done_o;
  logic [15:0]   Duration_ms_o, HalfPeriod_us_o;

  logic [31:0]   mem [0:(1<<AW)-1];
  logic [31:0]   data_q;

  int n_vec = 0;
  int n_err = 0;

  // reference model: whether a melody runs, which note is current, when the next fetch is judged
  bit          m_active   = 1'b0;
  bit          m_sounding = 1'b0;
  int          m_addr     = 0;
  int          m_start    = 0;
  int          m_cd       = 0;
  logic [15:0] m_dur      = 16'd0;
  logic [15:0] m_hp       = 16'd0;
  bit          m_sstart   = 1'b0;
  bit          m_sfin     = 1'b0;
  bit          m_done     = 1'b0;

  always #5 Clock = ~Clock;

  always @(posedge Clock) data_q <= mem[Address_o];
  assign Data_i = data_q;

  melody_player #(.ADDR_WIDTH(AW), .NOTE_GAP_CYCLES(GAP)) dut (
    .Clock(Clock), .Reset(Reset), .Start_i(Start_i), .Stop_i(Stop_i), .Loop_i(Loop_i),
    .StartAddr_i(StartAddr_i), .Address_o(Address_o), .Data_i(Data_i),
    .SoundStart_o(SoundStart_o), .SoundFinish_o(SoundFinish_o),
    .Duration_ms_o(Duration_ms_o), .HalfPeriod_us_o(HalfPeriod_us_o),
    .SoundDone_i(SoundDone_i), .Busy_o(Busy_o), .Done_o(Done_o)
  );

  task automatic model_step();
    logic [31:0] w;
    m_sstart = 1'b0;
    m_sfin   = 1'b0;
    m_done   = 1'b0;
    if (Reset) begin
      m_active = 1'b0; m_sounding = 1'b0; m_addr = 0; m_start = 0;
      m_dur = 16'd0; m_hp = 16'd0;
    end else if (!m_active) begin
      if (Start_i && !Stop_i) begin
        m_active = 1'b1; m_addr = int'(StartAddr_i); m_start = int'(StartAddr_i); m_cd = 2;
      end
    end else if (Stop_i) begin
      m_sfin = m_sounding; m_active = 1'b0; m_sounding = 1'b0;
    end else if (m_sounding) begin
      if (SoundDone_i) begin
        m_sounding = 1'b0;
        m_addr = (m_addr + 1) % (1 << AW);
        m_cd = GAP + 2;
      end
    end else begin
      m_cd = m_cd - 1;
      if (m_cd == 0) begin
        w = mem[m_addr];
        if (w[31:16] == 16'd0) begin
          if (Loop_i) begin
            m_addr = m_start; m_cd = 2;
          end else begin
            m_done = 1'b1; m_active = 1'b0;
          end
        end else begin
          m_dur = w[31:16]; m_hp = w[15:0]; m_sstart = 1'b1; m_sounding = 1'b1;
        end
      end
    end
  endtask

  task automatic cycle();
    logic [AW-1:0] ea;
    @(posedge Clock);
    model_step();
    @(negedge Clock);
    ea = AW'(m_addr);
    n_vec++;
    if ({Address_o, Duration_ms_o, HalfPeriod_us_o, Busy_o, SoundStart_o, SoundFinish_o, Done_o} !==
        {ea, m_dur, m_hp, m_active, m_sstart, m_sfin, m_done}) begin
      n_err++;
      $display("FAIL cycle t=%0t addr %h/%h dur %h/%h hp %h/%h busy %b/%b sstart %b/%b sfin %b/%b done %b/%b (got/want)",
               $time, Address_o, ea, Duration_ms_o, m_dur, HalfPeriod_us_o, m_hp, Busy_o, m_active,
               SoundStart_o, m_sstart, SoundFinish_o, m_sfin, Done_o, m_done);
    end
    Start_i = 1'b0; Stop_i = 1'b0; SoundDone_i = 1'b0; Reset = 1'b0;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < (1 << AW); i++) mem[i] = 32'd0;
  endtask

  task automatic start_melody(input logic [AW-1:0] a);
    StartAddr_i = a;
    Start_i = 1'b1;
    cycle();
  endtask

  initial begin
    Reset = 1'b1; Start_i = 1'b0; Stop_i = 1'b0; Loop_i = 1'b0; SoundDone_i = 1'b0;
    StartAddr_i = '0;
    clear_mem();
    @(negedge Clock);
    Reset = 1'b1; cycle();
    Reset = 1'b1; cycle();
    check("rst_addr", 32'(Address_o), 32'd0);
    check("rst_busy", 32'(Busy_o), 32'd0);
    check("rst_dur", 32'(Duration_ms_o), 32'd0);

    // two-note melody with end marker
    mem[0] = {16'd1, 16'd9}; mem[1] = {16'd2, 16'd0}; mem[2] = 32'd0;
    start_melody(4'd0);
    check("d1_busy", 32'(Busy_o), 32'd1);
    cycle(); cycle();
    check("d1_sstart", 32'(SoundStart_o), 32'd1);
    check("d1_dur", 32'(Duration_ms_o), 32'd1);
    check("d1_hp", 32'(HalfPeriod_us_o), 32'd9);
    cycle();
    check("d1_pulse", 32'(SoundStart_o), 32'd0);
    cycle();
    SoundDone_i = 1'b1; cycle();
    check("d1_addr1", 32'(Address_o), 32'd1);
    repeat (3) cycle();
    check("d1_gap", 32'(SoundStart_o), 32'd0);
    cycle();
    check("d1_sstart2", 32'(SoundStart_o), 32'd1);
    check("d1_dur2", 32'(Duration_ms_o), 32'd2);
    cycle();
    SoundDone_i = 1'b1; cycle();
    repeat (3) cycle();
    check("d1_done_early", 32'(Done_o), 32'd0);
    cycle();
    check("d1_done", 32'(Done_o), 32'd1);
    check("d1_idle", 32'(Busy_o), 32'd0);
    cycle();
    check("d1_done_pulse", 32'(Done_o), 32'd0);
    check("d1_hold", 32'(Duration_ms_o), 32'd2);

    // empty melody
    mem[5] = 32'd0;
    start_melody(4'd5);
    cycle(); cycle();
    check("d2_done", 32'(Done_o), 32'd1);
    check("d2_nostart", 32'(SoundStart_o), 32'd0);

    // looping melody, stopped while a note plays
    clear_mem();
    mem[0] = {16'd3, 16'd49};
    Loop_i = 1'b1;
    start_melody(4'd0);
    cycle(); cycle();
    check("d3_dur", 32'(Duration_ms_o), 32'd3);
    check("d3_hp", 32'(HalfPeriod_us_o), 32'd49);
    cycle();
    SoundDone_i = 1'b1; cycle();
    repeat (4) cycle();
    check("d3_wrap", 32'(Address_o), 32'd0);
    cycle(); cycle();
    check("d3_restart", 32'(SoundStart_o), 32'd1);
    cycle();
    Stop_i = 1'b1; cycle();
    check("d3_finish", 32'(SoundFinish_o), 32'd1);
    check("d3_busy", 32'(Busy_o), 32'd0);
    check("d3_nodone", 32'(Done_o), 32'd0);
    cycle();
    check("d3_finish_pulse", 32'(SoundFinish_o), 32'd0);
    Loop_i = 1'b0;

    // address wrap from the top of memory
    clear_mem();
    mem[15] = {16'd1, 16'd9};
    start_melody(4'd15);
    cycle(); cycle();
    check("d4_sstart", 32'(SoundStart_o), 32'd1);
    SoundDone_i = 1'b1; cycle();
    check("d4_addr", 32'(Address_o), 32'd0);
    repeat (4) cycle();
    check("d4_done", 32'(Done_o), 32'd1);

    // ignored starts, and reset while a note plays
    clear_mem();
    mem[0] = {16'd1, 16'd9};
    start_melody(4'd0);
    StartAddr_i = 4'd7; Start_i = 1'b1; cycle();
    check("d6_ignored", 32'(Address_o), 32'd0);
    cycle();
    check("d6_sstart", 32'(SoundStart_o), 32'd1);
    Stop_i = 1'b1; cycle();
    StartAddr_i = 4'd3; Start_i = 1'b1; Stop_i = 1'b1; cycle();
    check("d6_startstop", 32'(Busy_o), 32'd0);
    start_melody(4'd0);
    cycle(); cycle();
    Reset = 1'b1; cycle();
    check("d6_rst_dur", 32'(Duration_ms_o), 32'd0);
    check("d6_rst_hp", 32'(HalfPeriod_us_o), 32'd0);
    check("d6_rst_fin", 32'(SoundFinish_o), 32'd0);
    check("d6_rst_busy", 32'(Busy_o), 32'd0);

    // random traffic
    for (int c = 0; c < 4000; c++) begin
      if (!m_active && ($urandom_range(0, 15) == 0)) begin
        for (int i = 0; i < (1 << AW); i++) begin
          if ($urandom_range(0, 3) == 0) mem[i] = {16'd0, 16'($urandom)};
          else mem[i] = {16'($urandom_range(1, 20)), 16'($urandom)};
        end
      end
      Start_i     = ($urandom_range(0, 7) == 0);
      StartAddr_i = AW'($urandom_range(0, (1 << AW) - 1));
      Stop_i      = ($urandom_range(0, 39) == 0);
      Loop_i      = ($urandom_range(0, 3) == 0);
      SoundDone_i = m_sounding ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 19) == 0);
      Reset       = ($urandom_range(0, 499) == 0);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
